// File: rtl/cpu16_pkg.sv
// Shared definitions for the 16-bit CPU register bank: sizes, the zero-register
// index and the write-back slot record.
package cpu16_pkg;

    localparam int DATA_W = 16;
    localparam int NREG   = 8;
    localparam int SEL_W  = 3;

    localparam logic [SEL_W-1:0] REG_ZERO = 3'd0;

    typedef struct packed {
        logic              valid;
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wr_demux_dec.sv
// 3->8 one-hot decoder with enable; all outputs low when en=0.
module dec3_8
    import cpu16_pkg::*;
(
    input  logic             en,
    input  logic [SEL_W-1:0] sel,
    output logic [NREG-1:0]  onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_wr_demux.sv
// Write side of the 8 x 16-bit register bank: one-entry write-back slot,
// one-hot commit decode, and bypass of the pending write onto Q0..Q7.
module regfile_wr_demux #(
    parameter int DATA_W  = cpu16_pkg::DATA_W,
    parameter int NREG    = cpu16_pkg::NREG,
    parameter int SEL_W   = cpu16_pkg::SEL_W,
    parameter bit R0_ZERO = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [SEL_W-1:0]  wsel,
    input  logic [DATA_W-1:0] wd,
    input  logic              stall,
    output logic [DATA_W-1:0] Q0,
    output logic [DATA_W-1:0] Q1,
    output logic [DATA_W-1:0] Q2,
    output logic [DATA_W-1:0] Q3,
    output logic [DATA_W-1:0] Q4,
    output logic [DATA_W-1:0] Q5,
    output logic [DATA_W-1:0] Q6,
    output logic [DATA_W-1:0] Q7,
    output logic              wb_busy,
    output logic              wr_drop,
    output logic [7:0]        wr_cnt
);
    import cpu16_pkg::*;

    wb_req_t           slot_p0;
    logic [DATA_W-1:0] regs [NREG];
    logic [DATA_W-1:0] qv   [NREG];
    logic [NREG-1:0]   wen;
    logic [NREG-1:0]   hit;
    logic              r0_hit;
    logic              accept;
    logic              refuse;
    logic              commit;

    // A refused request is either one arriving under stall or one aimed at R0.
    assign r0_hit = R0_ZERO && (wsel == REG_ZERO);
    assign accept = we && !stall && !r0_hit;
    assign refuse = we && (stall || r0_hit);
    assign commit = slot_p0.valid && !stall;

    dec3_8 u_wen_dec (
        .en     (commit),
        .sel    (slot_p0.sel),
        .onehot (wen)
    );

    dec3_8 u_hit_dec (
        .en     (slot_p0.valid),
        .sel    (slot_p0.sel),
        .onehot (hit)
    );

    // ---- slot stage p0: a new request overwrites the slot while the old one commits
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_p0 <= '0;
            wr_drop <= 1'b0;
            wr_cnt  <= '0;
        end else begin
            if (accept) begin
                slot_p0 <= '{valid: 1'b1, sel: wsel, data: wd};
            end else if (commit) begin
                slot_p0.valid <= 1'b0;
            end
            wr_drop <= refuse;
            if (commit) begin
                wr_cnt <= wr_cnt + 8'd1;
            end
        end
    end

    // ---- commit stage: register array written from the slot
    for (genvar k = 0; k < NREG; k++) begin : g_reg
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                regs[k] <= '0;
            end else if (wen[k]) begin
                regs[k] <= slot_p0.data;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NREG; k++) begin
            qv[k] = hit[k] ? slot_p0.data : regs[k];
        end
        if (R0_ZERO) begin
            qv[0] = '0;
        end
    end

    assign Q0      = qv[0];
    assign Q1      = qv[1];
    assign Q2      = qv[2];
    assign Q3      = qv[3];
    assign Q4      = qv[4];
    assign Q5      = qv[5];
    assign Q6      = qv[6];
    assign Q7      = qv[7];
    assign wb_busy = slot_p0.valid;

endmodule

// File: tb/tb_regfile_wr_demux.sv
// Scenario bench for regfile_wr_demux with a queue of expected Q values.
module tb_regfile_wr_demux;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        we    = 1'b0;
    logic        stall = 1'b0;
    logic [2:0]  wsel  = '0;
    logic [15:0] wd    = '0;
    logic [15:0] Q0, Q1, Q2, Q3, Q4, Q5, Q6, Q7;
    logic        wb_busy, wr_drop;
    logic [7:0]  wr_cnt;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_cnt = 8'd0;

    typedef struct {
        int          idx;
        logic [15:0] val;
    } exp_t;
    exp_t sb[$];

    logic [15:0] q [8];
    assign q[0] = Q0;
    assign q[1] = Q1;
    assign q[2] = Q2;
    assign q[3] = Q3;
    assign q[4] = Q4;
    assign q[5] = Q5;
    assign q[6] = Q6;
    assign q[7] = Q7;

    regfile_wr_demux #(.R0_ZERO(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .we(we), .wsel(wsel), .wd(wd), .stall(stall),
        .Q0(Q0), .Q1(Q1), .Q2(Q2), .Q3(Q3), .Q4(Q4), .Q5(Q5), .Q6(Q6), .Q7(Q7),
        .wb_busy(wb_busy), .wr_drop(wr_drop), .wr_cnt(wr_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input logic w, input logic [2:0] s, input logic [15:0] d, input logic st);
        we = w; wsel = s; wd = d; stall = st;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int idx, input logic [15:0] val);
        exp_t e;
        e.idx = idx;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        cyc(1'b0, 3'd0, 16'h0, 1'b0);
        rst_n = 1'b1;
        exp_cnt = 8'd0;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (q[k] !== 16'h0) begin
                errors++;
                $display("FAIL reset_q%0d got %h want 0000", k, q[k]);
            end
        end
        checks++;
        if ({wb_busy, wr_drop, wr_cnt} !== 10'h0) begin
            errors++;
            $display("FAIL reset_ctrl got busy=%b drop=%b cnt=%0d want 0 0 0", wb_busy, wr_drop, wr_cnt);
        end
    endtask

    task automatic test_fill;
        logic [15:0] vals [8];
        exp_t e;
        vals = '{16'd0, 16'd29, 16'd38, 16'd51, 16'd64, 16'd82, 16'd94, 16'd112};
        for (int k = 1; k < 8; k++) begin
            push(k, vals[k]);
            cyc(1'b1, 3'(k), vals[k], 1'b0);
            e = sb.pop_front();
            checks++;
            if (q[e.idx] !== e.val) begin
                errors++;
                $display("FAIL fill_q%0d got %h want %h", e.idx, q[e.idx], e.val);
            end
        end
        exp_cnt = 8'd7;
        cyc(1'b0, 3'd0, 16'h0, 1'b0);
        cyc(1'b0, 3'd0, 16'h0, 1'b0);
        checks++;
        if (wr_cnt !== exp_cnt || wb_busy !== 1'b0) begin
            errors++;
            $display("FAIL fill_cnt got cnt=%0d busy=%b want %0d 0", wr_cnt, wb_busy, exp_cnt);
        end
        for (int s = 0; s < 8; s++) begin
            checks++;
            if (q[s] !== vals[s]) begin
                errors++;
                $display("FAIL readmux_sel%0d got %0d want %0d", s, q[s], vals[s]);
            end
        end
    endtask

    task automatic test_single;
        exp_t e;
        push(3, 16'hBEEF);
        cyc(1'b1, 3'd3, 16'hBEEF, 1'b0);
        e = sb.pop_front();
        checks++;
        if (q[e.idx] !== e.val || wb_busy !== 1'b1 || wr_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL single_bypass got q=%h busy=%b cnt=%0d want %h 1 %0d", q[e.idx], wb_busy, wr_cnt, e.val, exp_cnt);
        end
        exp_cnt++;
        push(3, 16'hBEEF);
        cyc(1'b0, 3'd0, 16'h0, 1'b0);
        e = sb.pop_front();
        checks++;
        if (q[e.idx] !== e.val || wb_busy !== 1'b0 || wr_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL single_commit got q=%h busy=%b cnt=%0d want %h 0 %0d", q[e.idx], wb_busy, wr_cnt, e.val, exp_cnt);
        end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        logic [15:0] v [3];
        v = '{16'h1111, 16'h2222, 16'h2222};
        for (int i = 0; i < 3; i++) begin
            push(5, v[i]);
            cyc(i < 2, 3'd5, v[i], 1'b0);
            if (i > 0) exp_cnt++;
            e = sb.pop_front();
            checks++;
            if (q[e.idx] !== e.val || wr_cnt !== exp_cnt) begin
                errors++;
                $display("FAIL b2b_step%0d got q5=%h cnt=%0d want %h %0d", i, q[e.idx], wr_cnt, e.val, exp_cnt);
            end
        end
        checks++;
        if (wb_busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_busy got %b want 0", wb_busy);
        end
    endtask

    task automatic test_stall;
        exp_t e;
        cyc(1'b1, 3'd2, 16'h00AA, 1'b0);
        for (int i = 0; i < 3; i++) begin
            push(2, 16'h00AA);
            push(4, 16'd64);
            cyc(i == 0, 3'd4, 16'h1234, 1'b1);
            e = sb.pop_front();
            checks++;
            if (q[e.idx] !== e.val) begin
                errors++;
                $display("FAIL stall_q2_c%0d got %h want %h", i, q[e.idx], e.val);
            end
            e = sb.pop_front();
            checks++;
            if (q[e.idx] !== e.val) begin
                errors++;
                $display("FAIL stall_q4_c%0d got %h want %h", i, q[e.idx], e.val);
            end
            checks++;
            if (wr_drop !== (i == 0) || wr_cnt !== exp_cnt || wb_busy !== 1'b1) begin
                errors++;
                $display("FAIL stall_ctrl_c%0d got drop=%b cnt=%0d busy=%b want %b %0d 1", i, wr_drop, wr_cnt, wb_busy, (i == 0), exp_cnt);
            end
        end
        exp_cnt++;
        cyc(1'b0, 3'd0, 16'h0, 1'b0);
        checks++;
        if (q[2] !== 16'h00AA || q[4] !== 16'd64 || wr_cnt !== exp_cnt || wb_busy !== 1'b0 || wr_drop !== 1'b0) begin
            errors++;
            $display("FAIL stall_release got q2=%h q4=%0d cnt=%0d busy=%b drop=%b want 00aa 64 %0d 0 0", q[2], q[4], wr_cnt, wb_busy, wr_drop, exp_cnt);
        end
    endtask

    task automatic test_r0;
        cyc(1'b1, 3'd0, 16'hFFFF, 1'b0);
        checks++;
        if (q[0] !== 16'h0 || wr_drop !== 1'b1 || wr_cnt !== exp_cnt || wb_busy !== 1'b0) begin
            errors++;
            $display("FAIL r0_write got q0=%h drop=%b cnt=%0d busy=%b want 0000 1 %0d 0", q[0], wr_drop, wr_cnt, wb_busy, exp_cnt);
        end
        cyc(1'b0, 3'd0, 16'h0, 1'b0);
        checks++;
        if (q[0] !== 16'h0 || wr_drop !== 1'b0 || wr_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL r0_after got q0=%h drop=%b cnt=%0d want 0000 0 %0d", q[0], wr_drop, wr_cnt, exp_cnt);
        end
    endtask

    task automatic test_reset_pending;
        cyc(1'b1, 3'd6, 16'h0042, 1'b0);
        checks++;
        if (q[6] !== 16'h0042) begin
            errors++;
            $display("FAIL rstpend_bypass got %h want 0042", q[6]);
        end
        rst_n = 1'b0;
        cyc(1'b0, 3'd0, 16'h0, 1'b0);
        rst_n = 1'b1;
        exp_cnt = 8'd0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (q[6] !== 16'h0 || wb_busy !== 1'b0 || wr_cnt !== exp_cnt) begin
                errors++;
                $display("FAIL rstpend_c%0d got q6=%h busy=%b cnt=%0d want 0000 0 0", i, q[6], wb_busy, wr_cnt);
            end
            cyc(1'b0, 3'd0, 16'h0, 1'b0);
        end
    endtask

    task automatic test_wrap;
        exp_t e;
        for (int i = 0; i < 256; i++) begin
            push(7, 16'(i));
            cyc(1'b1, 3'd7, 16'(i), 1'b0);
            e = sb.pop_front();
            if (i == 0 || i == 128 || i == 255) begin
                checks++;
                if (q[e.idx] !== e.val || wr_cnt !== 8'(i)) begin
                    errors++;
                    $display("FAIL wrap_i%0d got q7=%h cnt=%0d want %h %0d", i, q[e.idx], wr_cnt, e.val, i);
                end
            end
        end
        cyc(1'b0, 3'd0, 16'h0, 1'b0);
        checks++;
        if (wr_cnt !== 8'd0 || q[7] !== 16'd255 || wb_busy !== 1'b0) begin
            errors++;
            $display("FAIL wrap_final got cnt=%0d q7=%0d busy=%b want 0 255 0", wr_cnt, q[7], wb_busy);
        end
    endtask

    initial begin
        test_reset;
        test_fill;
        test_single;
        test_back_to_back;
        test_stall;
        test_r0;
        test_reset_pending;
        test_wrap;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left got %0d want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
